// File: rtl/icb_wdt.sv
`default_nettype none
// ----------------------------------------------------------------------------
// icb_wdt : ICB-mapped watchdog. It raises an IRQ on the first timeout and
//           pulses a reset request on the second consecutive timeout.
// Revision: 1.0
// ----------------------------------------------------------------------------
module icb_wdt #(
   parameter int unsigned CLK_DIV       = 1,
   parameter int unsigned RST_PULSE_CYC = 16,
   parameter logic [31:0] FEED_KEY      = 32'h5A5AA5A5
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wdt_icb_cmd_valid,
   output logic        wdt_icb_cmd_ready,
   input  logic [31:0] wdt_icb_cmd_addr,
   input  logic        wdt_icb_cmd_read,
   input  logic [31:0] wdt_icb_cmd_wdata,
   input  logic [3:0]  wdt_icb_cmd_wmask,
   output logic        wdt_icb_rsp_valid,
   input  logic        wdt_icb_rsp_ready,
   output logic        wdt_icb_rsp_err,
   output logic [31:0] wdt_icb_rsp_rdata,
   output logic        irq_wdt,
   output logic        wdt_rst_en
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_COUNT = 2'd1,
      ST_WARN  = 2'd2,
      ST_BITE  = 2'd3
   } state_e;

   localparam int unsigned      PRE_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned      PC_W     = (RST_PULSE_CYC > 1) ? $clog2(RST_PULSE_CYC) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);
   localparam logic [PC_W-1:0]  PC_LAST  = PC_W'(RST_PULSE_CYC - 1);

   logic [7:0]       off;
   logic             addr_ok, cmd_acc, wr_acc, key_ok, feed_wr, feed;
   logic             stat_wr, ctrl_wr, load_wr, running, tick, irq_set;
   logic [3:0]       ctrl_wval;
   logic [31:0]      rd_mux;
   logic             unused_addr_hi;

   state_e           state_q, state_d;
   logic [3:0]       ctrl_q, ctrl_d;
   logic [31:0]      load_q, load_d, cnt_q, cnt_d;
   logic [PRE_W-1:0] pre_q, pre_d;
   logic [PC_W-1:0]  pc_q, pc_d;
   logic             irq_q, irq_d, badkey_q, badkey_d;
   logic             rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
   logic [31:0]      rsp_rdata_q, rsp_rdata_d;

   assign unused_addr_hi    = ^wdt_icb_cmd_addr[31:8];
   assign off               = wdt_icb_cmd_addr[7:0];
   assign addr_ok           = (off[1:0] == 2'b00) && (off <= 8'h10);
   assign wdt_icb_cmd_ready = ~rsp_valid_q | wdt_icb_rsp_ready;
   assign cmd_acc           = wdt_icb_cmd_valid & wdt_icb_cmd_ready;
   assign wr_acc            = cmd_acc & ~wdt_icb_cmd_read & addr_ok;
   assign key_ok            = (wdt_icb_cmd_wmask == 4'hF) && (wdt_icb_cmd_wdata == FEED_KEY);
   assign running           = (state_q == ST_COUNT) || (state_q == ST_WARN);
   assign feed_wr           = wr_acc && (off == 8'h0C);
   assign feed              = feed_wr & key_ok & running;
   assign stat_wr           = wr_acc && (off == 8'h10) && wdt_icb_cmd_wmask[0];
   assign ctrl_wr           = wr_acc && (off == 8'h00) && wdt_icb_cmd_wmask[0] && !ctrl_q[3]
                              && (state_q != ST_BITE);
   assign load_wr           = wr_acc && (off == 8'h04) && !ctrl_q[3];
   assign tick              = (pre_q == PRE_LAST);
   // LOCK is sticky: once set, a write can never clear it.
   assign ctrl_wval         = ctrl_wr ? {ctrl_q[3] | wdt_icb_cmd_wdata[3], wdt_icb_cmd_wdata[2:0]}
                                      : ctrl_q;

   always_comb begin
      rd_mux = 32'd0;
      case (off)
         8'h00:   rd_mux = {28'd0, ctrl_q};
         8'h04:   rd_mux = load_q;
         8'h08:   rd_mux = cnt_q;
         8'h10:   rd_mux = {28'd0, state_q, badkey_q, irq_q};
         default: rd_mux = 32'd0;
      endcase
   end

   always_comb begin
      rsp_valid_d = rsp_valid_q;
      rsp_err_d   = rsp_err_q;
      rsp_rdata_d = rsp_rdata_q;
      load_d      = load_q;
      if (cmd_acc) begin
         rsp_valid_d = 1'b1;
         rsp_err_d   = ~addr_ok;
         rsp_rdata_d = (wdt_icb_cmd_read && addr_ok) ? rd_mux : 32'd0;
      end else if (wdt_icb_rsp_ready) begin
         rsp_valid_d = 1'b0;
      end
      if (load_wr) begin
         for (int b = 0; b < 4; b++) begin
            if (wdt_icb_cmd_wmask[b]) load_d[8*b +: 8] = wdt_icb_cmd_wdata[8*b +: 8];
         end
      end
      badkey_d = (badkey_q & ~(stat_wr & wdt_icb_cmd_wdata[1])) | (feed_wr & ~key_ok);
      irq_d    = (irq_q & ~(stat_wr & wdt_icb_cmd_wdata[0])) | irq_set;
   end

   always_comb begin
      state_d = state_q;
      ctrl_d  = ctrl_wval;
      cnt_d   = cnt_q;
      pre_d   = pre_q;
      pc_d    = pc_q;
      irq_set = 1'b0;
      case (state_q)
         ST_IDLE: begin
            pre_d = '0;
            pc_d  = '0;
            if (ctrl_wval[0] && !ctrl_q[0]) begin
               state_d = ST_COUNT;
               cnt_d   = load_q;
            end
         end
         ST_COUNT, ST_WARN: begin
            pre_d = tick ? '0 : pre_q + 1'b1;
            // Priority order: disable, then feed, then timeout.
            if (!ctrl_wval[0]) begin
               state_d = ST_IDLE;
               pre_d   = '0;
            end else if (feed) begin
               state_d = ST_COUNT;
               cnt_d   = load_q;
               pre_d   = '0;
            end else if (tick) begin
               if (cnt_q != 32'd0) begin
                  cnt_d = cnt_q - 32'd1;
               end else if ((state_q == ST_WARN) && ctrl_wval[2]) begin
                  state_d = ST_BITE;
                  pc_d    = '0;
               end else begin
                  state_d = ST_WARN;
                  irq_set = 1'b1;
                  cnt_d   = load_q;
               end
            end
         end
         ST_BITE: begin
            pre_d = '0;
            if (pc_q == PC_LAST) begin
               state_d   = ST_IDLE;
               ctrl_d[0] = 1'b0;
               pc_d      = '0;
            end else begin
               pc_d = pc_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         ctrl_q      <= 4'd0;
         load_q      <= 32'd0;
         cnt_q       <= 32'd0;
         pre_q       <= '0;
         pc_q        <= '0;
         irq_q       <= 1'b0;
         badkey_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= 32'd0;
      end else begin
         state_q     <= state_d;
         ctrl_q      <= ctrl_d;
         load_q      <= load_d;
         cnt_q       <= cnt_d;
         pre_q       <= pre_d;
         pc_q        <= pc_d;
         irq_q       <= irq_d;
         badkey_q    <= badkey_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   assign wdt_icb_rsp_valid = rsp_valid_q;
   assign wdt_icb_rsp_err   = rsp_err_q;
   assign wdt_icb_rsp_rdata = rsp_rdata_q;
   assign irq_wdt           = irq_q & ctrl_q[1];
   assign wdt_rst_en        = (state_q == ST_BITE);

endmodule
`default_nettype wire

// File: tb/tb_icb_wdt.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_icb_wdt : directed and randomized bench for icb_wdt against a deadline-
//              based behavioural model of the watchdog.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_icb_wdt;

   localparam int unsigned CLK_DIV       = 1;
   localparam int unsigned RST_PULSE_CYC = 16;
   localparam logic [31:0] FEED_KEY      = 32'h5A5AA5A5;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [31:0] cmd_addr = 32'd0;
   logic        cmd_read = 1'b0;
   logic [31:0] cmd_wdata = 32'd0;
   logic [3:0]  cmd_wmask = 4'd0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic        rsp_err;
   logic [31:0] rsp_rdata;
   logic        irq_wdt;
   logic        wdt_rst_en;

   int n_checks = 0;
   int n_errors = 0;
   int hs_cnt   = 0;
   bit irq_seen = 1'b0;

   // Model state: timeouts are absolute edge numbers, not a mirrored counter.
   logic [3:0]  m_ctrl;
   logic [31:0] m_load, m_ld, m_hold, m_rdata;
   logic [1:0]  m_state;
   logic        m_irq, m_bad, m_rv, m_rerr;
   longint      m_edge, m_start, m_bite;

   icb_wdt #(
      .CLK_DIV       (CLK_DIV),
      .RST_PULSE_CYC (RST_PULSE_CYC),
      .FEED_KEY      (FEED_KEY)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .wdt_icb_cmd_valid (cmd_valid),
      .wdt_icb_cmd_ready (cmd_ready),
      .wdt_icb_cmd_addr  (cmd_addr),
      .wdt_icb_cmd_read  (cmd_read),
      .wdt_icb_cmd_wdata (cmd_wdata),
      .wdt_icb_cmd_wmask (cmd_wmask),
      .wdt_icb_rsp_valid (rsp_valid),
      .wdt_icb_rsp_ready (rsp_ready),
      .wdt_icb_rsp_err   (rsp_err),
      .wdt_icb_rsp_rdata (rsp_rdata),
      .irq_wdt           (irq_wdt),
      .wdt_rst_en        (wdt_rst_en)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL global_timeout got=%0t exp=<1000000", $time);
      $fatal(1, "bench did not finish");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic m_reset();
      m_ctrl = 4'd0; m_load = 32'd0; m_ld = 32'd0; m_hold = 32'd0; m_rdata = 32'd0;
      m_state = 2'd0; m_irq = 1'b0; m_bad = 1'b0; m_rv = 1'b0; m_rerr = 1'b0;
      m_edge = 0; m_start = 0; m_bite = 0;
   endtask

   function automatic logic [31:0] cur_cnt();
      if (m_state == 2'd1 || m_state == 2'd2)
         return m_ld - 32'((m_edge - m_start) / longint'(CLK_DIV));
      return m_hold;
   endfunction

   task automatic model_step(input logic v, input logic [31:0] a, input logic rd,
                             input logic [31:0] wd, input logic [3:0] wm, input logic rr);
      logic [7:0]  o;
      logic [3:0]  n_ctrl;
      logic [31:0] n_load;
      logic        ok, acc, wr, good, tmo, irq_set, irq_clr, bad_clr, bad_set;
      longint      e;
      o   = a[7:0];
      ok  = (o[1:0] == 2'b00) && (o <= 8'h10);
      acc = v && (!m_rv || rr);
      wr  = acc && !rd && ok;
      e   = m_edge + 1;
      if (acc) begin
         m_rv = 1'b1; m_rerr = !ok; m_rdata = 32'd0;
         if (rd && ok) begin
            case (o)
               8'h00:   m_rdata = {28'd0, m_ctrl};
               8'h04:   m_rdata = m_load;
               8'h08:   m_rdata = cur_cnt();
               8'h10:   m_rdata = {28'd0, m_state, m_bad, m_irq};
               default: m_rdata = 32'd0;
            endcase
         end
      end else if (rr) begin
         m_rv = 1'b0;
      end
      n_ctrl = m_ctrl;
      n_load = m_load;
      if (wr && o == 8'h00 && wm[0] && !m_ctrl[3] && m_state != 2'd3)
         n_ctrl = {m_ctrl[3] | wd[3], wd[2:0]};
      if (wr && o == 8'h04 && !m_ctrl[3])
         for (int b = 0; b < 4; b++) if (wm[b]) n_load[8*b +: 8] = wd[8*b +: 8];
      good    = wr && o == 8'h0C && wm == 4'hF && wd == FEED_KEY;
      bad_set = wr && o == 8'h0C && !good;
      irq_clr = wr && o == 8'h10 && wm[0] && wd[0];
      bad_clr = wr && o == 8'h10 && wm[0] && wd[1];
      irq_set = 1'b0;
      tmo = (m_state == 2'd1 || m_state == 2'd2) &&
            (e == m_start + (longint'(m_ld) + 1) * longint'(CLK_DIV));
      case (m_state)
         2'd0: if (n_ctrl[0] && !m_ctrl[0]) begin
            m_state = 2'd1; m_start = e; m_ld = m_load;
         end
         2'd1, 2'd2: begin
            if (!n_ctrl[0]) begin
               m_hold = cur_cnt(); m_state = 2'd0;
            end else if (good) begin
               m_state = 2'd1; m_start = e; m_ld = m_load;
            end else if (tmo) begin
               if (m_state == 2'd2 && n_ctrl[2]) begin
                  m_hold = 32'd0; m_state = 2'd3; m_bite = e;
               end else begin
                  irq_set = 1'b1; m_state = 2'd2; m_start = e; m_ld = m_load;
               end
            end
         end
         default: if (e == m_bite + longint'(RST_PULSE_CYC)) begin
            m_state = 2'd0; n_ctrl[0] = 1'b0;
         end
      endcase
      m_ctrl = n_ctrl;
      m_load = n_load;
      m_irq  = (m_irq && !irq_clr) || irq_set;
      m_bad  = (m_bad && !bad_clr) || bad_set;
      m_edge = e;
   endtask

   // One clock cycle: drive at negedge, step model at posedge, compare at next negedge.
   task automatic cyc(input logic v, input logic [31:0] a, input logic rd,
                      input logic [31:0] wd, input logic [3:0] wm, input logic rr);
      cmd_valid = v; cmd_addr = a; cmd_read = rd; cmd_wdata = wd; cmd_wmask = wm;
      rsp_ready = rr;
      #1;
      check("cmd_ready", 32'(cmd_ready), 32'(!m_rv || rr));
      if (rsp_valid && rr) hs_cnt++;
      @(posedge clk);
      model_step(v, a, rd, wd, wm, rr);
      @(negedge clk);
      check("rsp_valid", 32'(rsp_valid), 32'(m_rv));
      check("rsp_err", 32'(rsp_err), 32'(m_rerr));
      check("rsp_rdata", rsp_rdata, m_rdata);
      check("irq_wdt", 32'(irq_wdt), 32'(m_irq && m_ctrl[1]));
      check("wdt_rst_en", 32'(wdt_rst_en), 32'(m_state == 2'd3));
      if (irq_wdt) irq_seen = 1'b1;
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(1'b0, 32'd0, 1'b1, 32'd0, 4'd0, 1'b1);
   endtask

   task automatic icb(input logic rd, input logic [7:0] o, input logic [31:0] wd,
                      output logic [31:0] d, output logic e);
      cyc(1'b1, {24'd0, o}, rd, wd, 4'hF, 1'b1);
      d = rsp_rdata;
      e = rsp_err;
   endtask

   task automatic do_reset();
      cmd_valid = 1'b0; cmd_addr = 32'd0; cmd_read = 1'b0; cmd_wdata = 32'd0;
      cmd_wmask = 4'd0; rsp_ready = 1'b1;
      rst_n = 1'b0;
      m_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [31:0] d;
      logic        e;
      logic [7:0]  offs [5];
      int          first_irq, first_rst, n_rst;
      offs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10};

      // Reset state and register readback
      do_reset();
      check("rst_irq", 32'(irq_wdt), 32'd0);
      check("rst_rsten", 32'(wdt_rst_en), 32'd0);
      check("rst_rspv", 32'(rsp_valid), 32'd0);
      for (int i = 0; i < 5; i++) begin
         icb(1'b1, offs[i], 32'd0, d, e);
         check("rst_read", d, 32'd0);
      end

      // First timeout: LOAD=9 gives IRQ exactly 10 cycles after enabling
      do_reset();
      icb(1'b0, 8'h04, 32'd9, d, e);
      icb(1'b0, 8'h00, 32'h3, d, e);
      idle(9);
      check("irq_before_10", 32'(irq_wdt), 32'd0);
      idle(1);
      check("irq_at_10", 32'(irq_wdt), 32'd1);
      icb(1'b1, 8'h08, 32'd0, d, e);
      check("cnt_reload", d, 32'd9);
      icb(1'b1, 8'h10, 32'd0, d, e);
      check("stat_warn", d, 32'h9);

      // Regular feeding keeps the IRQ away; a wrong key flags BADKEY
      do_reset();
      icb(1'b0, 8'h04, 32'd9, d, e);
      icb(1'b0, 8'h00, 32'h3, d, e);
      irq_seen = 1'b0;
      repeat (20) begin
         idle(4);
         icb(1'b0, 8'h0C, FEED_KEY, d, e);
      end
      check("feed_no_irq", 32'(irq_seen), 32'd0);
      icb(1'b0, 8'h0C, 32'h12345678, d, e);
      icb(1'b1, 8'h10, 32'd0, d, e);
      check("stat_badkey", d, 32'h6);

      // Second timeout with RST_EN produces a 16-cycle reset pulse
      do_reset();
      icb(1'b0, 8'h04, 32'd3, d, e);
      icb(1'b0, 8'h00, 32'h7, d, e);
      first_irq = -1; first_rst = -1; n_rst = 0;
      for (int k = 1; k <= 30; k++) begin
         idle(1);
         if (irq_wdt && first_irq < 0) first_irq = k;
         if (wdt_rst_en) begin
            n_rst++;
            if (first_rst < 0) first_rst = k;
         end
      end
      check("bite_irq_at", 32'(first_irq), 32'd4);
      check("bite_start", 32'(first_rst), 32'd8);
      check("bite_width", 32'(n_rst), 32'd16);
      icb(1'b1, 8'h00, 32'd0, d, e);
      check("bite_ctrl", d, 32'h6);
      icb(1'b1, 8'h10, 32'd0, d, e);
      check("bite_stat", d, 32'h1);

      // Reset in the middle of the pulse drops it at once
      do_reset();
      icb(1'b0, 8'h04, 32'd3, d, e);
      icb(1'b0, 8'h00, 32'h7, d, e);
      idle(12);
      check("pulse_active", 32'(wdt_rst_en), 32'd1);
      #2 rst_n = 1'b0;
      #1 check("pulse_async_clear", 32'(wdt_rst_en), 32'd0);
      m_reset();
      @(negedge clk);
      rst_n = 1'b1;

      // LOCK blocks CTRL/LOAD writes silently; out-of-map offset errors
      do_reset();
      icb(1'b0, 8'h00, 32'h8, d, e);
      icb(1'b0, 8'h04, 32'hFF, d, e);
      check("lock_load_err", 32'(e), 32'd0);
      icb(1'b0, 8'h00, 32'h1, d, e);
      check("lock_ctrl_err", 32'(e), 32'd0);
      icb(1'b1, 8'h04, 32'd0, d, e);
      check("lock_load", d, 32'd0);
      icb(1'b1, 8'h00, 32'd0, d, e);
      check("lock_ctrl", d, 32'h8);
      icb(1'b1, 8'h20, 32'd0, d, e);
      check("bad_addr_err", 32'(e), 32'd1);
      check("bad_addr_data", d, 32'd0);

      // Backpressure holds the response; then back-to-back throughput
      do_reset();
      icb(1'b0, 8'h04, 32'h55, d, e);
      idle(1);
      cyc(1'b1, 32'h04, 1'b1, 32'd0, 4'd0, 1'b0);
      repeat (3) begin
         cyc(1'b1, 32'h08, 1'b1, 32'd0, 4'd0, 1'b0);
         check("bp_ready", 32'(cmd_ready), 32'd0);
         check("bp_hold", rsp_rdata, 32'h55);
      end
      hs_cnt = 0;
      for (int i = 0; i < 5; i++)
         cyc(i < 4, {24'd0, offs[i]}, 1'b1, 32'd0, 4'd0, 1'b1);
      check("b2b_handshakes", 32'(hs_cnt), 32'd5);
      check("b2b_drained", 32'(rsp_valid), 32'd0);

      // Randomized traffic: frequent feeds first, then sparse feeds to reach BITE
      do_reset();
      icb(1'b0, 8'h04, 32'd5, d, e);
      icb(1'b0, 8'h00, 32'h3, d, e);
      for (int i = 0; i < 2400; i++) begin
         logic [31:0] a, wd;
         logic [3:0]  wm;
         logic [7:0]  o;
         logic        rr;
         int          r, fp;
         fp = (i < 1200) ? 15 : 3;
         r  = $urandom_range(0, 99);
         rr = ($urandom_range(0, 9) != 0);
         a  = $urandom;
         wd = $urandom;
         wm = 4'($urandom);
         case ($urandom_range(0, 5))
            0: o = 8'h00;
            1: o = 8'h04;
            2: o = 8'h08;
            3: o = 8'h0C;
            4: o = 8'h10;
            default: o = 8'($urandom);
         endcase
         if (i == 2000)        cyc(1'b1, {a[31:8], 8'h00}, 1'b0, 32'h9, 4'h1, rr);
         else if (r < 40)      cyc(1'b0, a, 1'b1, wd, wm, rr);
         else if (r < 40 + fp) cyc(1'b1, {a[31:8], 8'h0C}, 1'b0, FEED_KEY, 4'hF, rr);
         else if (r < 60)      cyc(1'b1, {a[31:8], 8'h0C}, 1'b0, wd, wm, rr);
         else if (r < 75)      cyc(1'b1, {a[31:8], o}, 1'b1, wd, wm, rr);
         else if (r < 82)      cyc(1'b1, {a[31:8], 8'h10}, 1'b0, {30'd0, wd[1:0]}, wm, rr);
         else if (r < 88)      cyc(1'b1, {a[31:8], 8'h04}, 1'b0, {28'd0, wd[3:0]}, wm, rr);
         else if (r < 97)      cyc(1'b1, {a[31:8], 8'h00}, 1'b0, {29'd0, wd[2:0]}, wm, rr);
         else                  cyc(1'b1, a, wd[0], wd, wm, rr);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
